// File: rtl/avalon_lsu_master.sv
// Load/store bus master: one request at a time onto the Avalon data bus, with waitrequest
// timeout, interconnect stall generation and load-data formatting.
module avalon_lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        stall_o,
  output logic [31:0] avalon_addr_o,
  output logic        avalon_read_o,
  output logic        avalon_write_o,
  output logic [3:0]  avalon_byteenable_o,
  output logic [31:0] avalon_writedata_o,
  input  logic        avalon_waitrequest_i,
  input  logic [31:0] avalon_readdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [1:0]      size;
  logic            we;
  logic            uns;
  logic [1:0]      err;
  logic [CntW-1:0] wait_cnt;

  logic        misaligned;
  logic        in_bus;
  logic        timeout_hit;
  logic [31:0] shifted;

  assign misaligned  = (req_size_i == 2'b01 && req_addr_i[0]) ||
                       (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign in_bus      = (state == StBus);
  // Waitrequest low wins over a timeout landing in the same cycle.
  assign timeout_hit = in_bus && avalon_waitrequest_i && (wait_cnt == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= StIdle;
      addr     <= '0;
      wdata    <= '0;
      size     <= '0;
      we       <= 1'b0;
      uns      <= 1'b0;
      err      <= 2'b00;
      wait_cnt <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid_i) begin
            addr     <= req_addr_i;
            wdata    <= req_wdata_i;
            size     <= req_size_i;
            we       <= req_we_i;
            uns      <= req_unsigned_i;
            wait_cnt <= '0;
            if (req_size_i == 2'b11) begin
              err   <= 2'b11;
              state <= StResp;
            end else if (misaligned) begin
              err   <= 2'b01;
              state <= StResp;
            end else begin
              err   <= 2'b00;
              state <= StBus;
            end
          end
        end
        StBus: begin
          if (!avalon_waitrequest_i) begin
            err   <= 2'b00;
            state <= StResp;
          end else if (timeout_hit) begin
            err   <= 2'b10;
            state <= StResp;
          end else if (wait_cnt != CntMax) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign req_ready_o    = (state == StIdle);
  assign rsp_valid_o    = (state == StResp);
  assign rsp_err_o      = rsp_valid_o ? err : 2'b00;
  assign stall_o        = in_bus && avalon_waitrequest_i && !timeout_hit;
  assign avalon_read_o  = in_bus && !we && !timeout_hit;
  assign avalon_write_o = in_bus && we && !timeout_hit;
  assign avalon_addr_o  = in_bus ? addr : 32'h0;

  always_comb begin
    avalon_byteenable_o = 4'b0000;
    avalon_writedata_o  = 32'h0;
    if (in_bus) begin
      unique case (size)
        2'b00: begin
          avalon_byteenable_o = 4'b0001 << addr[1:0];
          avalon_writedata_o  = {4{wdata[7:0]}};
        end
        2'b01: begin
          avalon_byteenable_o = 4'b0011 << addr[1:0];
          avalon_writedata_o  = {2{wdata[15:0]}};
        end
        default: begin
          avalon_byteenable_o = 4'b1111;
          avalon_writedata_o  = wdata;
        end
      endcase
    end
  end

  assign shifted = avalon_readdata_i >> {addr[1:0], 3'b000};

  always_comb begin
    rsp_rdata_o = 32'h0;
    if (rsp_valid_o && !we && err == 2'b00) begin
      unique case (size)
        2'b00:   rsp_rdata_o = {{24{shifted[7] & ~uns}}, shifted[7:0]};
        2'b01:   rsp_rdata_o = {{16{shifted[15] & ~uns}}, shifted[15:0]};
        default: rsp_rdata_o = shifted;
      endcase
    end
  end

endmodule
